// File: rtl/conv_stream_feeder_if.sv
// conv_stream_feeder_if: AXI4-Stream bundle between the feeder and the conv core.
// Ports (signals): tdata/tvalid/tlast driven by master, tready driven by slave.
interface conv_stream_feeder_if #(
   parameter int DATA_WIDTH = 256
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder: streams C kernel words then C*S*S pixel words from a
// staging memory onto the conv core's AXI4-Stream slave, tlast on the final word.
// Ports: clk, Reset_top (async, active-high), start, IMAGE_SIZE_choose,
//   CHANNEL_SIZE_choose, gap_cycles (FEEDER_GAP_EN only), mem_en/mem_addr/
//   mem_rdata (1-cycle read latency), m_axis (stream master), busy, done, cfg_err.
// Optional: define FEEDER_GAP_EN to insert gap_cycles idle cycles after each beat.
module conv_stream_feeder #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 21
) (
   input  logic                  clk,
   input  logic                  Reset_top,
   input  logic                  start,
   input  logic [2:0]            IMAGE_SIZE_choose,
   input  logic [1:0]            CHANNEL_SIZE_choose,
`ifdef FEEDER_GAP_EN
   input  logic [3:0]            gap_cycles,
`endif
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   conv_stream_feeder_if.master  m_axis,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t                state_q, state_d;
   logic                  ld_q, ld_d;
   logic [2:0]            img_q, img_d;
   logic [1:0]            ch_q, ch_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d;
   logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_WIDTH-1:0] snd_cnt_q, snd_cnt_d;
   logic                  rd_vld_q, rd_vld_d;
   logic [1:0]            occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  cfg_err_q, cfg_err_d;
`ifdef FEEDER_GAP_EN
   logic [3:0]            gap_q, gap_d;
   logic [3:0]            gap_cnt_q, gap_cnt_d;
`endif

   logic [12:0]           s_val, ss1;
   logic [8:0]            c_val;
   logic [ADDR_WIDTH-1:0] n_calc;
   logic                  tvalid_w, hs, last_beat, issue, illegal;
   logic [2:0]            fill;

   // N = C*(S*S+1); S*S+1 peaks at 4097, which fits 13 bits.
   always_comb begin
      s_val  = 13'd4 << img_q;
      ss1    = s_val * s_val + 13'd1;
      c_val  = 9'd256 >> ch_q;
      n_calc = ADDR_WIDTH'(c_val) * ADDR_WIDTH'(ss1);
   end

   assign illegal   = IMAGE_SIZE_choose > 3'd4;
`ifdef FEEDER_GAP_EN
   assign tvalid_w  = (occ_q != 2'd0) && (gap_cnt_q == 4'd0);
`else
   assign tvalid_w  = (occ_q != 2'd0);
`endif
   assign hs        = tvalid_w & m_axis.tready;
   assign last_beat = snd_cnt_q == n_q - ADDR_WIDTH'(1);

   // Occupancy after this cycle's pop and landing read; a pop frees its slot
   // in the same cycle so a full-rate stream never starves the skid FIFO.
   assign fill  = {1'b0, occ_q} + {2'b0, rd_vld_q} - {2'b0, hs};
   // First RUN cycle only registers N; reads start the cycle after.
   assign issue = (state_q == RUN) && !ld_q
                  && (rd_cnt_q < n_q) && (fill < 3'd2);

   assign mem_en        = issue;
   assign mem_addr      = rd_cnt_q;
   assign m_axis.tdata  = head_q;
   assign m_axis.tvalid = tvalid_w;
   assign m_axis.tlast  = tvalid_w && last_beat;
   assign busy          = state_q == RUN;
   assign done          = state_q == FINISH;
   assign cfg_err       = cfg_err_q;

   always_comb begin
      state_d   = state_q;
      ld_d      = 1'b0;
      img_d     = img_q;
      ch_d      = ch_q;
      n_d       = n_q;
      rd_cnt_d  = rd_cnt_q;
      snd_cnt_d = snd_cnt_q;
      cfg_err_d = 1'b0;
`ifdef FEEDER_GAP_EN
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      if (hs)
         gap_cnt_d = gap_q;
      else if (gap_cnt_q != 4'd0)
         gap_cnt_d = gap_cnt_q - 4'd1;
`endif
      if (issue)
         rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
      if (hs)
         snd_cnt_d = snd_cnt_q + ADDR_WIDTH'(1);
      unique case (state_q)
         IDLE: begin
            if (start && illegal) begin
               cfg_err_d = 1'b1;
            end else if (start) begin
               img_d     = IMAGE_SIZE_choose;
               ch_d      = CHANNEL_SIZE_choose;
               rd_cnt_d  = '0;
               snd_cnt_d = '0;
               ld_d      = 1'b1;
               state_d   = RUN;
`ifdef FEEDER_GAP_EN
               gap_d     = gap_cycles;
               gap_cnt_d = 4'd0;
`endif
            end
         end
         RUN: begin
            if (ld_q)
               n_d = n_calc;
            if (hs && last_beat)
               state_d = FINISH;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Two-entry skid FIFO: head is presented, tail absorbs one extra word.
   always_comb begin
      rd_vld_d = issue;
      occ_d    = fill[1:0];
      head_d   = head_q;
      tail_d   = tail_q;
      if (hs)
         head_d = tail_q;
      if (rd_vld_q) begin
         if (occ_q == 2'd0 || (occ_q == 2'd1 && hs))
            head_d = mem_rdata;
         else
            tail_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge Reset_top) begin
      if (Reset_top)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge Reset_top) begin
      if (Reset_top) begin
         ld_q      <= 1'b0;
         img_q     <= '0;
         ch_q      <= '0;
         n_q       <= '0;
         rd_cnt_q  <= '0;
         snd_cnt_q <= '0;
         rd_vld_q  <= 1'b0;
         occ_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         cfg_err_q <= 1'b0;
`ifdef FEEDER_GAP_EN
         gap_q     <= '0;
         gap_cnt_q <= '0;
`endif
      end else begin
         ld_q      <= ld_d;
         img_q     <= img_d;
         ch_q      <= ch_d;
         n_q       <= n_d;
         rd_cnt_q  <= rd_cnt_d;
         snd_cnt_q <= snd_cnt_d;
         rd_vld_q  <= rd_vld_d;
         occ_q     <= occ_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cfg_err_q <= cfg_err_d;
`ifdef FEEDER_GAP_EN
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder: directed bench with scoreboard queue and
// handshake monitor for conv_stream_feeder.
module tb_conv_stream_feeder;
   localparam int DW = 256;
   localparam int AW = 21;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          Reset_top;
   logic          start;
   logic [2:0]    img;
   logic [1:0]    ch;
`ifdef FEEDER_GAP_EN
   logic [3:0]    gap_cycles;
`endif
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;
   logic          busy, done, cfg_err;

   conv_stream_feeder_if #(.DATA_WIDTH(DW)) axis ();

   conv_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk                 (clk),
      .Reset_top           (Reset_top),
      .start               (start),
      .IMAGE_SIZE_choose   (img),
      .CHANNEL_SIZE_choose (ch),
`ifdef FEEDER_GAP_EN
      .gap_cycles          (gap_cycles),
`endif
      .mem_en              (mem_en),
      .mem_addr            (mem_addr),
      .mem_rdata           (mem_rdata),
      .m_axis              (axis),
      .busy                (busy),
      .done                (done),
      .cfg_err             (cfg_err)
   );

   always #5 clk = ~clk;

   int    chk = 0, err = 0;
   beat_t sb[$];
   beat_t b;
   int    beats, reads, rd_exp, cyc, first_hs, last_hs, low_run;
   int    gap_exp, cfgerr_cnt, rdy_mode, rdy_ph;
   bit    chk_gap, pend_done, prev_stall;
   logic [DW-1:0] prev_d;
   logic          prev_l;

   // Memory model: word i holds value i, 1-cycle read latency.
   always @(posedge clk)
      if (mem_en) mem_rdata <= DW'(mem_addr);

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      rdy_ph = (rdy_ph + 1) % 6;
      axis.tready = (rdy_mode == 0) || (rdy_ph == 0);
   end

   always @(negedge clk) begin
      if (Reset_top) begin
         prev_stall = 0;
         pend_done  = 0;
      end else begin
         if (cfg_err) cfgerr_cnt++;
         if (mem_en) begin
            chk++;
            if (mem_addr !== AW'(rd_exp)) begin
               err++;
               $display("FAIL rd_addr got %0d want %0d", mem_addr, rd_exp);
            end
            rd_exp++;
            reads++;
         end
         if (pend_done) begin
            chk++;
            if (!(done === 1'b1 && busy === 1'b0)) begin
               err++;
               $display("FAIL done_pulse got done=%b busy=%b want 1/0", done, busy);
            end
            pend_done = 0;
         end else if (done) begin
            chk++;
            err++;
            $display("FAIL spurious_done got 1 want 0");
         end
         if (prev_stall) begin
            chk++;
            if (axis.tvalid !== 1'b1 || axis.tdata !== prev_d || axis.tlast !== prev_l) begin
               err++;
               $display("FAIL stall_hold got v=%b d=%0h l=%b want 1 %0h %b",
                        axis.tvalid, axis.tdata, axis.tlast, prev_d, prev_l);
            end
         end
         if (axis.tvalid && axis.tready) begin
            chk++;
            if (sb.size() == 0) begin
               err++;
               $display("FAIL extra_beat got %0h want none", axis.tdata);
            end else begin
               b = sb.pop_front();
               if (axis.tdata !== b.d || axis.tlast !== b.l) begin
                  err++;
                  $display("FAIL beat got %0h/%b want %0h/%b", axis.tdata, axis.tlast, b.d, b.l);
               end
            end
            if (chk_gap && beats != 0) begin
               chk++;
               if (low_run != gap_exp) begin
                  err++;
                  $display("FAIL gap got %0d want %0d", low_run, gap_exp);
               end
            end
            if (beats == 0) first_hs = cyc;
            last_hs = cyc;
            beats++;
            low_run = 0;
            if (axis.tlast) pend_done = 1;
         end else if (!axis.tvalid) begin
            low_run++;
         end
         prev_stall = axis.tvalid && !axis.tready;
         prev_d = axis.tdata;
         prev_l = axis.tlast;
      end
   end

   task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fill(int n);
      for (int i = 0; i < n; i++) sb.push_back('{d: DW'(i), l: (i == n - 1)});
   endtask

   task automatic new_run();
      beats = 0; reads = 0; rd_exp = 0; low_run = 0;
   endtask

   task automatic pulse_start(logic [2:0] s, logic [1:0] c);
      @(posedge clk); #1;
      img = s; ch = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(int budget, string nm);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done !== 1'b1 && k < budget);
      chk++;
      if (done !== 1'b1) begin
         err++;
         $display("FAIL %s_timeout got no done want done within %0d", nm, budget);
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outs(string nm);
      check({nm, "_mem_en"}, DW'(mem_en), '0);
      check({nm, "_mem_addr"}, DW'(mem_addr), '0);
      check({nm, "_tvalid"}, DW'(axis.tvalid), '0);
      check({nm, "_tlast"}, DW'(axis.tlast), '0);
      check({nm, "_tdata"}, axis.tdata, '0);
      check({nm, "_busy"}, DW'(busy), '0);
      check({nm, "_done"}, DW'(done), '0);
      check({nm, "_cfg_err"}, DW'(cfg_err), '0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      int c0, r0;
      bit hit;
      Reset_top = 1'b1; start = 1'b0; img = '0; ch = '0;
      rdy_mode = 0; rdy_ph = 0; chk_gap = 0; gap_exp = 0; cfgerr_cnt = 0;
      cyc = 0; first_hs = 0; last_hs = 0;
`ifdef FEEDER_GAP_EN
      gap_cycles = '0;
`endif
      new_run();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset");
      @(posedge clk); #1;
      Reset_top = 1'b0;

      // Nominal 4x4, C=256: N = 4352, plus start latency
      new_run(); fill(4352); chk_gap = 1; gap_exp = 0;
      pulse_start(3'd0, 2'd0);
      repeat (2) @(negedge clk);
      check("lat_busy", DW'(busy), DW'(1));
      check("lat_mem_en", DW'(mem_en), DW'(1));
      check("lat_mem_addr", DW'(mem_addr), '0);
      @(negedge clk);
      check("lat_tvalid_early", DW'(axis.tvalid), '0);
      @(negedge clk);
      check("lat_tvalid", DW'(axis.tvalid), DW'(1));
      check("lat_word0", axis.tdata, '0);
      wait_done(6000, "nominal");
      check("nom_beats", DW'(beats), DW'(4352));
      check("nom_reads", DW'(reads), DW'(4352));
      check("nom_sb_left", DW'(sb.size()), '0);
      check("nom_span", DW'(last_hs - first_hs + 1), DW'(4352));

      // Backpressure 8x8, C=32: N = 32*65 = 2080
      new_run(); fill(2080); chk_gap = 0; rdy_mode = 1;
      pulse_start(3'd1, 2'd3);
      wait_done(15000, "bp");
      rdy_mode = 0;
      check("bp_beats", DW'(beats), DW'(2080));
      check("bp_reads", DW'(reads), DW'(2080));
      check("bp_sb_left", DW'(sb.size()), '0);

      // Illegal config
      r0 = reads; c0 = cfgerr_cnt;
      pulse_start(3'd5, 2'd0);
      @(negedge clk);
      check("ill_cfg_err", DW'(cfg_err), DW'(1));
      check("ill_busy", DW'(busy), '0);
      @(negedge clk);
      check("ill_cfg_err_pulse", DW'(cfg_err), '0);
      repeat (5) @(negedge clk);
      check("ill_no_read", DW'(reads - r0), '0);
      check("ill_busy_after", DW'(busy), '0);
      check("ill_err_count", DW'(cfgerr_cnt - c0), DW'(1));

      // Start while busy: 4x4, C=32 -> N = 544
      new_run(); fill(544); chk_gap = 1; gap_exp = 0;
      pulse_start(3'd0, 2'd3);
      repeat (40) @(negedge clk);
      c0 = cfgerr_cnt;
      pulse_start(3'd4, 2'd0);
      repeat (3) @(negedge clk);
      pulse_start(3'd7, 2'd0);
      wait_done(2000, "busy_start");
      check("bs_beats", DW'(beats), DW'(544));
      check("bs_reads", DW'(reads), DW'(544));
      check("bs_no_cfg_err", DW'(cfgerr_cnt - c0), '0);
      check("bs_sb_left", DW'(sb.size()), '0);

      // Mid-stream reset at beat 100, then a fresh full run
      new_run(); fill(4352);
      pulse_start(3'd0, 2'd0);
      hit = 0;
      for (int k = 0; k < 1000 && !hit; k++) begin
         @(posedge clk); #3;
         if (beats >= 100) hit = 1;
      end
      chk++;
      if (!hit) begin
         err++;
         $display("FAIL mid_reach100 got %0d want 100", beats);
      end
      Reset_top = 1'b1;
      #1;
      check_reset_outs("midrst");
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      Reset_top = 1'b0;
      new_run(); fill(4352);
      pulse_start(3'd0, 2'd0);
      wait_done(6000, "restart");
      check("rs_beats", DW'(beats), DW'(4352));
      check("rs_reads", DW'(reads), DW'(4352));
      check("rs_sb_left", DW'(sb.size()), '0);
      check("rs_span", DW'(last_hs - first_hs + 1), DW'(4352));

`ifdef FEEDER_GAP_EN
      gap_cycles = 4'd3;
      new_run(); fill(4352); chk_gap = 1; gap_exp = 3;
      pulse_start(3'd0, 2'd0);
      gap_cycles = 4'd0;
      wait_done(20000, "gap");
      check("gap_beats", DW'(beats), DW'(4352));
      check("gap_span", DW'(last_hs - first_hs + 1), DW'(4 * 4352 - 3));
      check("gap_sb_left", DW'(sb.size()), '0);
`endif

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule
